countdown_timer: RTL and testbench

Countdown counterpart to the team's stopwatch. Loads a preset and decrements it once per prescaled tick while running, using the same start/stop push-button semantics. On reaching zero it expires, emits a one-cycle done pulse and holds at zero. It sits beside the stopwatch on the button and display bus; o_data drives the same display path.

---
 rtl/timer_pkg.sv | 15 +
 rtl/button_debounce.sv | 41 ++++
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: state encoding and default parameters shared by the countdown timer and the stopwatch.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEBOUNCE = 3;
    localparam int DEF_TICK_DIV = 1;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, stable-count debounce and one-cycle pulse on the debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1, sync2, level, level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            pulse   <= level & ~level_q;
            // any agreeing sample restarts the stability count
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with debounced start/stop buttons, prescaled ticks and a done pulse on expiry.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_running,
    output logic             o_expired,
    output logic             o_done
);

    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    state_t        state;
    logic [PW-1:0] presc;
    logic          start_ev, stop_ev, go, halt, tick;

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_start (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .btn   (i_start),
        .pulse (start_ev)
    );

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_stop (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .btn   (i_stop),
        .pulse (stop_ev)
    );

    // simultaneous start and stop cancel each other
    assign go   = start_ev & ~stop_ev;
    assign halt = stop_ev & ~start_ev;
    assign tick = presc == PW'(TICK_DIV - 1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            presc     <= '0;
            o_data    <= '0;
            o_running <= 1'b0;
            o_expired <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_load && state != RUNNING) begin
                state     <= IDLE;
                o_data    <= i_load_value;
                o_running <= 1'b0;
                o_expired <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSED: begin
                        if (go && o_data != '0) begin
                            state     <= RUNNING;
                            o_running <= 1'b1;
                            presc     <= '0;
                        end else if (halt) begin
                            state  <= IDLE;
                            o_data <= '0;
                        end
                    end
                    RUNNING: begin
                        // a stop landing on a tick cycle suppresses the decrement
                        if (halt) begin
                            state     <= PAUSED;
                            o_running <= 1'b0;
                        end else if (tick) begin
                            presc  <= '0;
                            o_data <= o_data - 1'b1;
                            if (o_data == WIDTH'(1)) begin
                                state     <= EXPIRED;
                                o_running <= 1'b0;
                                o_expired <= 1'b1;
                                o_done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    EXPIRED: begin
                        if (halt) begin
                            state     <= IDLE;
                            o_expired <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: two instances (TICK_DIV 1 and 4) checked by directed timelines and a behavioural model under random buttons.
module tb_countdown_timer;
    import timer_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int D = DEF_DEBOUNCE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] lv = '0;
    logic [W-1:0] data [2];
    logic         run [2];
    logic         expd [2];
    logic         done [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .DEBOUNCE(D), .TICK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_load_value(lv),
        .i_start(start), .i_stop(stop), .o_data(data[0]), .o_running(run[0]),
        .o_expired(expd[0]), .o_done(done[0])
    );

    countdown_timer #(.WIDTH(W), .DEBOUNCE(D), .TICK_DIV(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_load_value(lv),
        .i_start(start), .i_stop(stop), .o_data(data[1]), .o_running(run[1]),
        .o_expired(expd[1]), .o_done(done[1])
    );

    // Reference model: a button level flips once the last D synchronised samples
    // (raw input two edges late) all disagree with it; a press acts two edges after the flip.
    bit           hs[$], hp[$], us[$], up[$];
    bit           ls, lp;
    logic [W-1:0] md [2];
    state_t       ms [2];
    int           mph [2];
    bit           mdone [2];

    function automatic bit settled(bit h[$], bit lvl);
        for (int i = 2; i < D + 2; i++)
            if ((i < h.size() ? h[i] : 1'b0) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit fs, fp, rs, rp, es, ep;
        int tdj;
        if (!rst_n) begin
            hs.delete(); hp.delete(); us.delete(); up.delete();
            ls = 1'b0; lp = 1'b0;
            for (int j = 0; j < 2; j++) begin
                md[j] = '0; ms[j] = IDLE; mph[j] = 0; mdone[j] = 1'b0;
            end
        end else begin
            hs.push_front(start);
            hp.push_front(stop);
            fs = settled(hs, ls);
            fp = settled(hp, lp);
            ls ^= fs;
            lp ^= fp;
            us.push_front(fs && ls);
            up.push_front(fp && lp);
            while (hs.size() > D + 2) void'(hs.pop_back());
            while (hp.size() > D + 2) void'(hp.pop_back());
            while (us.size() > 3) void'(us.pop_back());
            while (up.size() > 3) void'(up.pop_back());
            rs = us.size() > 2 ? us[2] : 1'b0;
            rp = up.size() > 2 ? up[2] : 1'b0;
            es = rs && !rp;
            ep = rp && !rs;
            for (int j = 0; j < 2; j++) begin
                tdj = j ? 4 : 1;
                mdone[j] = 1'b0;
                if (load && ms[j] != RUNNING) begin
                    md[j] = lv; ms[j] = IDLE;
                end else if (ms[j] == RUNNING) begin
                    if (ep) ms[j] = PAUSED;
                    else begin
                        mph[j]++;
                        if (mph[j] % tdj == 0) begin
                            md[j] = md[j] - 1'b1;
                            if (md[j] == '0) begin ms[j] = EXPIRED; mdone[j] = 1'b1; end
                        end
                    end
                end else if (ms[j] == EXPIRED) begin
                    if (ep) ms[j] = IDLE;
                end else if (es && md[j] != '0) begin
                    ms[j] = RUNNING; mph[j] = 0;
                end else if (ep) begin
                    ms[j] = IDLE; md[j] = '0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; lv = W'(v);
        tick(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({data[j], run[j], expd[j], done[j]} !== '0) begin
                failures++;
                $display("FAIL reset_initial dut%0d: got data=%0d run=%b exp=%b done=%b, expected all zero", j, data[j], run[j], expd[j], done[j]);
            end
        end
        rst_n = 1'b1;
        tick(1);
        do_load(10);
        start = 1'b1;
        tick(8);
        start = 1'b0;
        checks++;
        if (run[1] !== 1'b1 || data[1] !== W'(10)) begin
            failures++;
            $display("FAIL reset_precondition: got run=%b data=%0d, expected run=1 data=10", run[1], data[1]);
        end
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({data[j], run[j], expd[j], done[j]} !== '0) begin
                failures++;
                $display("FAIL reset_async dut%0d: got data=%0d run=%b exp=%b done=%b, expected all zero", j, data[j], run[j], expd[j], done[j]);
            end
        end
        tick(1);
        rst_n = 1'b1;
        tick(10);
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({data[j], run[j], expd[j], done[j]} !== '0) begin
                failures++;
                $display("FAIL reset_after dut%0d: got data=%0d run=%b exp=%b done=%b, expected all zero", j, data[j], run[j], expd[j], done[j]);
            end
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] ed;
        do_reset();
        do_load(5);
        start = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            tick(1);
            ed = e < 7 ? W'(5) : (e >= 11 ? W'(0) : W'(11 - e));
            checks++;
            if ({data[0], run[0], expd[0], done[0]} !== {ed, e >= 6 && e < 11, e >= 11, e == 11}) begin
                failures++;
                $display("FAIL basic edge %0d: got data=%0d run=%b exp=%b done=%b, expected data=%0d run=%b exp=%b done=%b",
                         e, data[0], run[0], expd[0], done[0], ed, e >= 6 && e < 11, e >= 11, e == 11);
            end
        end
        start = 1'b0;
        tick(5);
        checks++;
        if (data[0] !== '0 || expd[0] !== 1'b1 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold: got data=%0d exp=%b done=%b, expected data=0 exp=1 done=0", data[0], expd[0], done[0]);
        end
    endtask

    task automatic test_prescale;
        int           cp_i [7] = '{10, 12, 19, 26, 33, 34, 35};
        logic [W-1:0] cp_d [7] = '{2, 2, 2, 2, 1, 0, 0};
        logic [2:0]   cp_f [7] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b011, 3'b010};
        do_reset();
        do_load(3);
        for (int i = 0; i <= 36; i++) begin
            start = i inside {[0:4], [20:24]};
            stop  = i inside {[6:10]};
            tick(1);
            for (int k = 0; k < 7; k++)
                if (i == cp_i[k]) begin
                    checks++;
                    if ({data[1], run[1], expd[1], done[1]} !== {cp_d[k], cp_f[k]}) begin
                        failures++;
                        $display("FAIL prescale edge %0d: got data=%0d run/exp/done=%b%b%b, expected data=%0d run/exp/done=%b",
                                 i, data[1], run[1], expd[1], done[1], cp_d[k], cp_f[k]);
                    end
                end
        end
    endtask

    task automatic test_debounce;
        int           cp_i [6] = '{14, 30, 31, 60, 61, 75};
        logic [W-1:0] cp_d [6] = '{20, 20, 20, 13, 13, 13};
        logic [2:0]   cp_f [6] = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
        do_reset();
        do_load(20);
        for (int i = 0; i <= 76; i++) begin
            start = i inside {0, 1, 20, 22, 23, [25:33], 36, 37};
            stop  = i inside {50, 52, 53, [55:62], 65, 66};
            tick(1);
            for (int k = 0; k < 6; k++)
                if (i == cp_i[k]) begin
                    checks++;
                    if ({data[1], run[1], expd[1], done[1]} !== {cp_d[k], cp_f[k]}) begin
                        failures++;
                        $display("FAIL debounce edge %0d: got data=%0d run/exp/done=%b%b%b, expected data=%0d run/exp/done=%b",
                                 i, data[1], run[1], expd[1], done[1], cp_d[k], cp_f[k]);
                    end
                end
        end
    endtask

    task automatic test_stop;
        int           cp_i [9] = '{6, 8, 17, 18, 30, 32, 40, 42, 44};
        logic [W-1:0] cp_d [9] = '{7, 7, 7, 0, 0, 5, 5, 5, 4};
        logic [2:0]   cp_f [9] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100};
        do_reset();
        do_load(7);
        for (int i = 0; i <= 45; i++) begin
            start = i inside {[0:4], [22:26], [34:38]};
            stop  = i inside {[2:6], [12:16]};
            load  = i == 32 || i == 42;
            lv    = i == 42 ? W'(9) : W'(5);
            tick(1);
            for (int k = 0; k < 9; k++)
                if (i == cp_i[k]) begin
                    checks++;
                    if ({data[1], run[1], expd[1], done[1]} !== {cp_d[k], cp_f[k]}) begin
                        failures++;
                        $display("FAIL stop edge %0d: got data=%0d run/exp/done=%b%b%b, expected data=%0d run/exp/done=%b",
                                 i, data[1], run[1], expd[1], done[1], cp_d[k], cp_f[k]);
                    end
                end
        end
        load = 1'b0;
    endtask

    task automatic test_races;
        int           cp_i [6] = '{7, 18, 22, 30, 38, 45};
        logic [W-1:0] cp_d [6] = '{6, 1, 1, 1, 13, 13};
        logic [2:0]   cp_f [6] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        do_reset();
        do_load(6);
        for (int i = 0; i <= 46; i++) begin
            start = i inside {[0:4], [12:16]};
            stop  = i inside {[0:4], [16:20], [32:36]};
            load  = i == 10 || i == 38;
            lv    = i == 38 ? W'(13) : W'(1);
            tick(1);
            if (i >= 18 && i <= 30) begin
                checks++;
                if (done[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL race_no_done edge %0d: got done=%b, expected 0", i, done[1]);
                end
            end
            for (int k = 0; k < 6; k++)
                if (i == cp_i[k]) begin
                    checks++;
                    if ({data[1], run[1], expd[1], done[1]} !== {cp_d[k], cp_f[k]}) begin
                        failures++;
                        $display("FAIL race edge %0d: got data=%0d run/exp/done=%b%b%b, expected data=%0d run/exp/done=%b",
                                 i, data[1], run[1], expd[1], done[1], cp_d[k], cp_f[k]);
                    end
                end
        end
        load = 1'b0;
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            load = $urandom_range(0, 29) == 0;
            lv   = W'($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 9) == 0) stop = ~stop;
            rst_n = $urandom_range(0, 499) != 0;
            tick(1);
            for (int j = 0; j < 2; j++) begin
                checks++;
                if ({data[j], run[j], expd[j], done[j]} !== {md[j], ms[j] == RUNNING, ms[j] == EXPIRED, mdone[j]}) begin
                    failures++;
                    $display("FAIL random dut%0d cycle %0d: got data=%0d run=%b exp=%b done=%b, expected data=%0d run=%b exp=%b done=%b",
                             j, c, data[j], run[j], expd[j], done[j], md[j], ms[j] == RUNNING, ms[j] == EXPIRED, mdone[j]);
                end
            end
        end
        rst_n = 1'b1;
        load  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_debounce();
        test_stop();
        test_races();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
